// File: rtl/csr_pkg.sv
// Shared CSR definitions: operation encoding, PWM register offsets and the
// read-modify-write helper used by CSR-mapped blocks.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_RW = 2'd0,
        CSR_RS = 2'd1,
        CSR_RC = 2'd2
    } CsrOp;

    localparam int PwmCtrlIdx     = 0;
    localparam int PwmPrescaleIdx = 1;
    localparam int PwmPeriodIdx   = 2;
    localparam int PwmDutyIdx     = 3;

    typedef struct packed {
        logic inv;
        logic en;
    } pwm_ctrl_t;

    function automatic logic [31:0] csr_apply(input CsrOp op, input logic [31:0] old_val,
                                              input logic [31:0] data);
        logic [31:0] res;
        case (op)
            CSR_RW:  res = data;
            CSR_RS:  res = old_val | data;
            CSR_RC:  res = old_val & ~data;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler plus period counter. wrap marks the tick on
// which the counter returns to zero and channel duties reload.
module pwm_timebase #(
    parameter int Width    = 8,
    parameter int PreWidth = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [PreWidth-1:0] prescale,
    input  logic [Width-1:0]    period,
    output logic [Width-1:0]    cnt,
    output logic                wrap
);

    logic [PreWidth-1:0] pre_r;
    logic [Width-1:0]    cnt_r;
    logic                tick_s;
    logic                wrap_s;

    // >= on both compares so a limit lowered below the running value ends the
    // current interval on the next tick instead of running the counter around.
    assign tick_s = en && (pre_r >= prescale);
    assign wrap_s = tick_s && (cnt_r >= period);

    // Prescaler and period counter; held at zero while disabled.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            pre_r <= {PreWidth{1'b0}};
            cnt_r <= {Width{1'b0}};
        end else begin
            if (tick_s) begin
                pre_r <= {PreWidth{1'b0}};
            end else begin
                pre_r <= pre_r + 1'b1;
            end
            if (wrap_s) begin
                cnt_r <= {Width{1'b0}};
            end else if (tick_s) begin
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

    assign cnt  = cnt_r;
    assign wrap = wrap_s;

endmodule

// File: rtl/csr_pwm.sv
// CSR-mapped PWM bank: control/prescale/period registers, per-channel shadow
// duties that commit on period wrap, and registered channel outputs.
module csr_pwm
    import csr_pkg::*;
#(
    parameter int          Channels = 4,
    parameter int          Width    = 8,
    parameter int          PreWidth = 16,
    parameter logic [11:0] CsrBase  = 12'h400
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                csr_enable,
    input  logic [11:0]         csr_addr,
    input  CsrOp                csr_op,
    input  logic [31:0]         csr_data,
    output logic [31:0]         csr_out,
    output logic [Channels-1:0] pwm
);

    localparam int SelW = (Channels > 1) ? $clog2(Channels) : 1;

    pwm_ctrl_t           ctrl_r;
    logic [PreWidth-1:0] prescale_r;
    logic [Width-1:0]    period_r;
    logic [Width-1:0]    duty_r   [Channels];
    logic [Width-1:0]    active_r [Channels];
    logic [Channels-1:0] pwm_r;

    logic [11:0]         off_s;
    logic [11:0]         doff_s;
    logic [SelW-1:0]     dsel_s;
    logic                hit_s;
    logic [31:0]         cur_s;
    logic [31:0]         wdata_s;
    logic                wr_s;
    logic [31:0]         duty_rd_s [Channels];
    logic [Width-1:0]    cnt_s;
    logic                wrap_s;

    // Offset arithmetic wraps addresses below the base to large values, so a
    // single upper-bound compare decodes the whole window.
    assign off_s  = csr_addr - CsrBase;
    assign doff_s = off_s - 12'(PwmDutyIdx);
    assign dsel_s = doff_s[SelW-1:0];
    assign hit_s  = (off_s < 12'(PwmDutyIdx + Channels));

    for (genvar g = 0; g < Channels; g++) begin : g_duty_rd
        assign duty_rd_s[g] = 32'(duty_r[g]);
    end

    // Current value of the addressed register, zero-extended.
    always_comb begin
        cur_s = 32'd0;
        case (off_s)
            12'(PwmCtrlIdx):     cur_s = {30'd0, ctrl_r};
            12'(PwmPrescaleIdx): cur_s = 32'(prescale_r);
            12'(PwmPeriodIdx):   cur_s = 32'(period_r);
            default: begin
                if (hit_s) begin
                    cur_s = duty_rd_s[dsel_s];
                end else begin
                    cur_s = 32'd0;
                end
            end
        endcase
    end

    assign csr_out = (csr_enable && hit_s) ? cur_s : 32'd0;
    assign wdata_s = csr_apply(csr_op, cur_s, csr_data);
    assign wr_s    = csr_enable && hit_s &&
                     ((csr_op == CSR_RW) ||
                      (((csr_op == CSR_RS) || (csr_op == CSR_RC)) && (csr_data != 32'd0)));

    // Shared control, prescale and period registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r     <= pwm_ctrl_t'(2'b00);
            prescale_r <= {PreWidth{1'b0}};
            period_r   <= {Width{1'b0}};
        end else if (wr_s) begin
            case (off_s)
                12'(PwmCtrlIdx):     ctrl_r     <= pwm_ctrl_t'(wdata_s[1:0]);
                12'(PwmPrescaleIdx): prescale_r <= wdata_s[PreWidth-1:0];
                12'(PwmPeriodIdx):   period_r   <= wdata_s[Width-1:0];
                default:             ctrl_r     <= ctrl_r;
            endcase
        end
    end

    pwm_timebase #(
        .Width    (Width),
        .PreWidth (PreWidth)
    ) u_timebase (
        .clk      (clk),
        .reset    (reset),
        .en       (ctrl_r.en),
        .prescale (prescale_r),
        .period   (period_r),
        .cnt      (cnt_s),
        .wrap     (wrap_s)
    );

    // Per-channel shadow duty, active duty reload on wrap, and output compare.
    // The reload reads duty_r before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Channels; i++) begin
                duty_r[i]   <= {Width{1'b0}};
                active_r[i] <= {Width{1'b0}};
            end
            pwm_r <= {Channels{1'b0}};
        end else begin
            for (int i = 0; i < Channels; i++) begin
                if (wr_s && (off_s == 12'(PwmDutyIdx + i))) begin
                    duty_r[i] <= wdata_s[Width-1:0];
                end
                if (wrap_s) begin
                    active_r[i] <= duty_r[i];
                end
                pwm_r[i] <= ctrl_r.en ? ((cnt_s < active_r[i]) ^ ctrl_r.inv) : ctrl_r.inv;
            end
        end
    end

    assign pwm = pwm_r;

endmodule

// File: tb/tb_csr_pwm.sv
// Directed bench for csr_pwm: CSR ops, shadowed duty commit, edge duties,
// inversion/disable, prescaled timing, period shrink and mid-period reset.
module tb_csr_pwm;
    import csr_pkg::*;

    localparam logic [11:0] BASE = 12'h400;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_enable;
    logic [11:0] csr_addr;
    CsrOp        csr_op;
    logic [31:0] csr_data;
    logic [31:0] csr_out;
    logic [3:0]  pwm;

    int          total = 0;
    int          bad = 0;
    logic [3:0]  smp_pwm;
    logic [31:0] smp_out;
    logic [3:0]  exp_tab [32];
    logic [17:0] ps_exp;
    logic [19:0] sh_exp;

    always #5 clk = ~clk;

    csr_pwm #(
        .Channels (4),
        .Width    (8),
        .PreWidth (16),
        .CsrBase  (12'h400)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .csr_enable (csr_enable),
        .csr_addr   (csr_addr),
        .csr_op     (csr_op),
        .csr_data   (csr_data),
        .csr_out    (csr_out),
        .pwm        (pwm)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample pwm at the negedge, drive the CSR bus, sample csr_out.
    task automatic cyc(input logic e, input CsrOp op, input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        smp_pwm    = pwm;
        csr_enable = e;
        csr_op     = op;
        csr_addr   = a;
        csr_data   = d;
        #1 smp_out = csr_out;
    endtask

    task automatic idle();
        cyc(1'b0, CSR_RW, 12'h000, 32'd0);
    endtask

    task automatic wr(input CsrOp op, input logic [11:0] a, input logic [31:0] d);
        cyc(1'b1, op, a, d);
    endtask

    task automatic wait_pwm0(input logic v, input int lim, input string tag);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < lim && !ok; k++) begin
            idle();
            if (smp_pwm[0] === v) ok = 1'b1;
        end
        check_val(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_tab = '{4'b1101, 4'b1101, 4'b1100, 4'b0100, 4'b1101, 4'b1101, 4'b1100, 4'b0100,
                    4'b1101, 4'b1101, 4'b1100, 4'b0100, 4'b1101, 4'b1100, 4'b1100, 4'b0100,
                    4'b1101, 4'b1100, 4'b1100, 4'b0100, 4'b1101, 4'b1101, 4'b1101, 4'b0100,
                    4'b1101, 4'b1101, 4'b0010, 4'b1011, 4'b0010, 4'b0010, 4'b0010, 4'b1111};
        ps_exp = 18'b111111111_000_111_000;
        sh_exp = 20'b1111111_000000_11111_00;

        reset      = 1'b1;
        csr_enable = 1'b0;
        csr_op     = CSR_RW;
        csr_addr   = 12'h000;
        csr_data   = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Reset state over the whole window
        for (int a = 0; a < 7; a++) begin
            wr(CSR_RS, BASE + 12'(a), 32'd0);
            check_val($sformatf("rst_csr%0d", a), smp_out, 32'd0);
            check_val($sformatf("rst_pwm%0d", a), {28'd0, smp_pwm}, 32'd0);
        end

        // Configure: period 4, duties 2/0/8(upper bits dropped)/3
        wr(CSR_RW, BASE + 12'd1, 32'd0);
        wr(CSR_RW, BASE + 12'd2, 32'd3);
        wr(CSR_RW, BASE + 12'd3, 32'd2);
        wr(CSR_RW, BASE + 12'd4, 32'd0);
        wr(CSR_RW, BASE + 12'd5, 32'h108);
        wr(CSR_RW, BASE + 12'd6, 32'd3);
        wr(CSR_RS, BASE + 12'd5, 32'd0);
        check_val("duty2_rd", smp_out, 32'd8);
        wr(CSR_RS, BASE + 12'd2, 32'd0);
        check_val("period_rd", smp_out, 32'd3);
        wr(CSR_RW, BASE, 32'd1);

        // Waveform, shadow writes, inversion and disable
        wait_pwm0(1'b1, 20, "align1");
        check_val("wave0", {28'd0, smp_pwm}, {28'd0, exp_tab[0]});
        for (int n = 1; n < 32; n++) begin
            case (n)
                9:       wr(CSR_RW, BASE + 12'd3, 32'd1);
                14:      wr(CSR_RW, BASE + 12'd3, 32'd3);
                24:      wr(CSR_RS, BASE, 32'd2);
                25:      wr(CSR_RS, BASE, 32'd0);
                29:      wr(CSR_RC, BASE, 32'd1);
                30:      wr(CSR_RS, BASE, 32'd0);
                default: idle();
            endcase
            check_val($sformatf("wave%0d", n), {28'd0, smp_pwm}, {28'd0, exp_tab[n]});
            if (n == 24) check_val("rs_old", smp_out, 32'd1);
            if (n == 25) check_val("rs_new", smp_out, 32'd3);
            if (n == 29) check_val("rc_old", smp_out, 32'd3);
            if (n == 30) check_val("rc_new", smp_out, 32'd2);
        end

        // Misses outside the window leave state intact
        wr(CSR_RW, BASE - 12'd1, 32'hFFFF);
        check_val("miss_lo", smp_out, 32'd0);
        wr(CSR_RW, BASE + 12'd7, 32'hFF);
        check_val("miss_hi", smp_out, 32'd0);
        wr(CSR_RS, BASE, 32'd0);
        check_val("ctrl_intact", smp_out, 32'd2);
        wr(CSR_RS, BASE + 12'd2, 32'd0);
        check_val("period_intact", smp_out, 32'd3);
        wr(CSR_RS, BASE + 12'd3, 32'd0);
        check_val("duty0_intact", smp_out, 32'd3);
        check_val("miss_pwm", {28'd0, smp_pwm}, 32'hF);

        // Prescale 2, period 1: 6-cycle wrap, stale duty 3 until first wrap
        wr(CSR_RW, BASE, 32'd0);
        wr(CSR_RW, BASE + 12'd1, 32'd2);
        wr(CSR_RW, BASE + 12'd2, 32'd1);
        wr(CSR_RW, BASE + 12'd3, 32'd1);
        wr(CSR_RW, BASE, 32'd1);
        idle();
        check_val("ps_off", {31'd0, smp_pwm[0]}, 32'd0);
        for (int k = 0; k < 18; k++) begin
            idle();
            check_val($sformatf("ps%0d", k), {31'd0, smp_pwm[0]}, {31'd0, ps_exp[17-k]});
        end

        // Period shrink 200 -> 10 at cnt 50 wraps on the next tick
        wr(CSR_RW, BASE, 32'd0);
        wr(CSR_RW, BASE + 12'd1, 32'd0);
        wr(CSR_RW, BASE + 12'd2, 32'd200);
        wr(CSR_RW, BASE + 12'd3, 32'd60);
        wr(CSR_RW, BASE, 32'd1);
        wait_pwm0(1'b1, 10, "sh_a");
        wait_pwm0(1'b0, 10, "sh_b");
        wait_pwm0(1'b1, 300, "sh_c");
        wr(CSR_RW, BASE + 12'd3, 32'd5);
        repeat (48) idle();
        wr(CSR_RW, BASE + 12'd2, 32'd10);
        for (int k = 0; k < 20; k++) begin
            idle();
            check_val($sformatf("sh%0d", k), {31'd0, smp_pwm[0]}, {31'd0, sh_exp[19-k]});
        end

        // Reset mid-period
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check_val("mid_rst_pwm", {28'd0, pwm}, 32'd0);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            wr(CSR_RS, BASE + 12'(a), 32'd0);
            check_val($sformatf("mid_rst_csr%0d", a), smp_out, 32'd0);
        end
        idle();
        check_val("mid_rst_idle", {28'd0, smp_pwm}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
